// File: rtl/cargador_programa.sv
// cargador_programa: boot loader that streams a header, little-endian words and an XOR checksum
// into instruction memory, then releases the datapath from reset.
module cargador_programa #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wd,
    output logic              core_reset,
    output logic [ADDR_W:0]   words_loaded,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECK, RUN, ERROR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d, words_q, words_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       buf_q, buf_d;
    logic [7:0]        csum_q, csum_d;
    logic              im_we_q, im_we_d, byte_ready_q, byte_ready_d;
    logic              core_reset_q, core_reset_d, done_q, done_d, error_q, error_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wd_q, im_wd_d;
    logic              take;

    assign take = byte_valid && byte_ready_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        words_d   = words_q;
        lane_d    = lane_q;
        buf_d     = buf_q;
        csum_d    = csum_q;
        im_we_d   = 1'b0;
        im_addr_d = im_addr_q;
        im_wd_d   = im_wd_q;
        if (start) begin
            state_d = HEADER;
            n_d     = '0;
            words_d = '0;
            lane_d  = '0;
            buf_d   = '0;
            csum_d  = '0;
        end else if (take) begin
            case (state_q)
                HEADER: begin
                    if (byte_in != 8'd0 && byte_in <= 8'(DEPTH)) begin
                        n_d     = byte_in[ADDR_W:0];
                        words_d = '0;
                        lane_d  = '0;
                        csum_d  = '0;
                        state_d = DATA;
                    end else begin
                        state_d = ERROR;
                    end
                end
                DATA: begin
                    // bytes shift in from the top so lanes 0..2 end up LSB-first
                    csum_d = csum_q ^ byte_in;
                    lane_d = lane_q + 2'd1;
                    buf_d  = {byte_in, buf_q[23:8]};
                    if (lane_q == 2'd3) begin
                        im_we_d   = 1'b1;
                        im_addr_d = words_q[ADDR_W-1:0];
                        im_wd_d   = {byte_in, buf_q};
                        words_d   = words_q + 1'b1;
                        state_d   = (words_q + 1'b1 == n_q) ? CHECK : DATA;
                    end
                end
                CHECK:   state_d = (byte_in == csum_q) ? RUN : ERROR;
                default: ;
            endcase
        end
        byte_ready_d = (state_d == HEADER) || (state_d == DATA) || (state_d == CHECK);
        core_reset_d = state_d != RUN;
        done_d       = state_d == RUN;
        error_d      = state_d == ERROR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            words_q      <= '0;
            lane_q       <= '0;
            buf_q        <= '0;
            csum_q       <= '0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wd_q      <= '0;
            byte_ready_q <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            words_q      <= words_d;
            lane_q       <= lane_d;
            buf_q        <= buf_d;
            csum_q       <= csum_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wd_q      <= im_wd_d;
            byte_ready_q <= byte_ready_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wd        = im_wd_q;
    assign core_reset   = core_reset_q;
    assign words_loaded = words_q;
    assign done         = done_q;
    assign error        = error_q;
endmodule

// File: tb/tb_cargador_programa.sv
// tb_cargador_programa: directed scenarios for the program loader; writes are logged by a monitor
// and each task compares against hand-computed values.
module tb_cargador_programa;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready, im_we, core_reset, done, error;
    logic [4:0]  im_addr;
    logic [31:0] im_wd;
    logic [5:0]  words_loaded;

    int total = 0;
    int bad = 0;
    int wn = 0;
    logic [4:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    cargador_programa #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wd(im_wd),
        .core_reset(core_reset), .words_loaded(words_loaded), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we && wn < 64) begin
            wr_addr[wn] = im_addr;
            wr_data[wn] = im_wd;
            wn = wn + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        byte_valid = 1'b0;
        tick(gap);
        byte_in = b;
        byte_valid = 1'b1;
        t = 0;
        while (!byte_ready && t < 40) begin
            tick(1);
            t++;
        end
        if (t >= 40) begin
            total++;
            bad++;
            $display("FAIL send_timeout byte_ready=%0b required=1", byte_ready);
        end
        tick(1);
        byte_valid = 1'b0;
    endtask

    task automatic send_nominal(input logic [7:0] csum, input int maxgap);
        logic [7:0] s [0:9];
        s = '{8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        s[9] = csum;
        for (int i = 0; i < 10; i++) send_byte(s[i], maxgap == 0 ? 0 : $urandom_range(0, maxgap));
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        total++;
        if ({core_reset, byte_ready, im_we, done, error} !== 5'b10000 || words_loaded !== 6'd0 ||
            im_addr !== 5'd0 || im_wd !== 32'd0) begin
            bad++;
            $display("FAIL reset cr/rdy/we/done/err=%b%b%b%b%b wl=%0d addr=%0d wd=%h required 10000 0 0 0",
                     core_reset, byte_ready, im_we, done, error, words_loaded, im_addr, im_wd);
        end
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_nominal();
        wn = 0;
        pulse_start();
        total++;
        if (byte_ready !== 1'b1 || core_reset !== 1'b1) begin
            bad++;
            $display("FAIL header_ready rdy=%b cr=%b required 1 1", byte_ready, core_reset);
        end
        send_byte(8'h02, 0);
        for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h13 : (i == 2 ? 8'h50 : 8'h00), 0);
        total++;
        if (im_we !== 1'b1 || im_addr !== 5'd0 || im_wd !== 32'h00500013 || words_loaded !== 6'd1) begin
            bad++;
            $display("FAIL write0_latency we=%b addr=%0d wd=%h wl=%0d required 1 0 00500013 1",
                     im_we, im_addr, im_wd, words_loaded);
        end
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'hC0, 0);
        tick(1);
        total++;
        if (wn !== 2 || wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h00500013 ||
            wr_addr[1] !== 5'd1 || wr_data[1] !== 32'h00100093) begin
            bad++;
            $display("FAIL nominal_writes n=%0d a0=%0d d0=%h a1=%0d d1=%h required 2 0 00500013 1 00100093",
                     wn, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
        total++;
        if (done !== 1'b1 || core_reset !== 1'b0 || words_loaded !== 6'd2 || error !== 1'b0 || byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL nominal_status done=%b cr=%b wl=%0d err=%b rdy=%b required 1 0 2 0 0",
                     done, core_reset, words_loaded, error, byte_ready);
        end
    endtask

    task automatic test_checksum_fail();
        wn = 0;
        pulse_start();
        send_nominal(8'hC1, 0);
        total++;
        if (error !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0 || words_loaded !== 6'd2 ||
            byte_ready !== 1'b0 || wn !== 2) begin
            bad++;
            $display("FAIL checksum_fail err=%b cr=%b done=%b wl=%0d rdy=%b writes=%0d required 1 1 0 2 0 2",
                     error, core_reset, done, words_loaded, byte_ready, wn);
        end
    endtask

    task automatic test_bad_header();
        logic [7:0] hdr [0:1];
        hdr = '{8'h00, 8'h21};
        for (int i = 0; i < 2; i++) begin
            wn = 0;
            pulse_start();
            send_byte(hdr[i], 0);
            tick(2);
            total++;
            if (error !== 1'b1 || wn !== 0 || byte_ready !== 1'b0 || core_reset !== 1'b1) begin
                bad++;
                $display("FAIL bad_header hdr=%h err=%b writes=%0d rdy=%b cr=%b required 1 0 0 1",
                         hdr[i], error, wn, byte_ready, core_reset);
            end
        end
        wn = 0;
        pulse_start();
        send_byte(8'h20, 0);
        total++;
        if (error !== 1'b0 || byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL header_32 err=%b rdy=%b required 0 1", error, byte_ready);
        end
        for (int i = 0; i < 128; i++) send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tick(1);
        total++;
        if (done !== 1'b1 || words_loaded !== 6'd32 || wn !== 32 || wr_addr[31] !== 5'd31) begin
            bad++;
            $display("FAIL full_load done=%b wl=%0d writes=%0d last_addr=%0d required 1 32 32 31",
                     done, words_loaded, wn, wr_addr[31]);
        end
    endtask

    task automatic test_gapped();
        wn = 0;
        byte_in = 8'h55;
        byte_valid = 1'b1;
        tick(4);
        total++;
        if (wn !== 0 || done !== 1'b1 || words_loaded !== 6'd32) begin
            bad++;
            $display("FAIL valid_in_run writes=%0d done=%b wl=%0d required 0 1 32", wn, done, words_loaded);
        end
        byte_valid = 1'b0;
        pulse_start();
        send_nominal(8'hC0, 3);
        tick(1);
        total++;
        if (wn !== 2 || wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h00500013 ||
            wr_addr[1] !== 5'd1 || wr_data[1] !== 32'h00100093 || done !== 1'b1) begin
            bad++;
            $display("FAIL gapped_writes n=%0d a0=%0d d0=%h a1=%0d d1=%h done=%b required 2 0 00500013 1 00100093 1",
                     wn, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], done);
        end
    endtask

    task automatic test_restart();
        wn = 0;
        pulse_start();
        send_byte(8'h03, 0);
        for (int i = 0; i < 6; i++) send_byte(8'h11 * i, 0);
        total++;
        if (words_loaded !== 6'd1 || wn !== 1) begin
            bad++;
            $display("FAIL partial_words wl=%0d writes=%0d required 1 1", words_loaded, wn);
        end
        byte_in = 8'h00;
        byte_valid = 1'b1;
        pulse_start();
        byte_valid = 1'b0;
        tick(1);
        total++;
        if (words_loaded !== 6'd0 || byte_ready !== 1'b1 || error !== 1'b0 || core_reset !== 1'b1) begin
            bad++;
            $display("FAIL restart_clear wl=%0d rdy=%b err=%b cr=%b required 0 1 0 1",
                     words_loaded, byte_ready, error, core_reset);
        end
        wn = 0;
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 2);
        send_byte(8'h00, 0);
        tick(1);
        total++;
        if (wn !== 1 || wr_addr[0] !== 5'd0 || wr_data[0] !== 32'hDDCCBBAA || done !== 1'b1 || words_loaded !== 6'd1) begin
            bad++;
            $display("FAIL restart_load n=%0d a0=%0d d0=%h done=%b wl=%0d required 1 0 ddccbbaa 1 1",
                     wn, wr_addr[0], wr_data[0], done, words_loaded);
        end
    endtask

    task automatic test_async_reset();
        wn = 0;
        pulse_start();
        send_byte(8'h02, 0);
        for (int i = 0; i < 7; i++) send_byte(8'h01, 0);
        byte_in = 8'h01;
        byte_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({core_reset, byte_ready, im_we, done, error} !== 5'b10000 || words_loaded !== 6'd0 ||
            im_addr !== 5'd0 || im_wd !== 32'd0) begin
            bad++;
            $display("FAIL async_reset cr/rdy/we/done/err=%b%b%b%b%b wl=%0d addr=%0d wd=%h required 10000 0 0 0",
                     core_reset, byte_ready, im_we, done, error, words_loaded, im_addr, im_wd);
        end
        tick(2);
        reset = 1'b1;
        tick(3);
        byte_valid = 1'b0;
        total++;
        if (wn !== 1 || byte_ready !== 1'b0 || core_reset !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_write writes=%0d rdy=%b cr=%b required 1 0 1", wn, byte_ready, core_reset);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_checksum_fail();
        test_bad_header();
        test_gapped();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
